// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N valid/ready/data input channels,
// the select/mode controls, and a single registered output stream.
interface stream_mux_rr_if #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int M = 2
);
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [M-1:0]   sel;
    logic           mode;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [M-1:0]   out_ch;
    logic           out_ready;

    // Producers/consumer side: drives inputs and the output-side ready.
    modport master (
        output in_valid, in_data, sel, mode, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Multiplexer side.
    modport slave (
        input  in_valid, in_data, sel, mode, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed or round-robin selection and one
// registered output stage. Define STREAM_MUX_RR_XFER_CNT_EN to add xfer_cnt.
module stream_mux_rr #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int M = 2
) (
    input  logic          clk,
    input  logic          rst,
    stream_mux_rr_if.slave bus
`ifdef STREAM_MUX_RR_XFER_CNT_EN
    ,
    output logic [15:0]   xfer_cnt
`endif
);

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic [M-1:0] out_ch_q,    out_ch_d;
    logic [M-1:0] last_grant_q, last_grant_d;

    logic         load;
    logic         fx_found;
    logic [M-1:0] fx_idx;
    logic         rr_found;
    logic [M-1:0] rr_idx;
    logic         gnt_valid;
    logic [M-1:0] gnt;
    logic [W-1:0] gnt_data;
    logic         accept;
    int           rr_start;
    int           rr_dist;
    int           rr_best;

    // The register may be refilled in the same cycle it drains.
    assign load = !out_valid_q || bus.out_ready;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        fx_found = 1'b0;
        fx_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(bus.sel) == i && bus.in_valid[i]) begin
                fx_found = 1'b1;
                fx_idx   = M'(i);
            end
        end
    end

    // Round-robin: pick the valid channel closest after last_grant, with wrap.
    always_comb begin
        rr_idx   = '0;
        rr_start = (int'(last_grant_q) + 1) % N;
        rr_best  = N;
        rr_dist  = 0;
        for (int i = 0; i < N; i++) begin
            rr_dist = (i - rr_start + N) % N;
            if (bus.in_valid[i] && rr_dist < rr_best) begin
                rr_best = rr_dist;
                rr_idx  = M'(i);
            end
        end
        rr_found = (rr_best < N);
    end

    always_comb begin
        if (bus.mode == MODE_RR) begin
            gnt_valid = rr_found;
            gnt       = rr_idx;
        end else begin
            gnt_valid = fx_found;
            gnt       = fx_idx;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(gnt) == i) begin
                gnt_data = bus.in_data[i*W +: W];
            end
        end
    end

    assign accept = !rst && load && gnt_valid;

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = accept && (int'(gnt) == i);
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        if (load) begin
            out_valid_d = gnt_valid;
            if (gnt_valid) begin
                out_data_d = gnt_data;
                out_ch_d   = gnt;
            end
        end
        // Fixed-mode transfers move the rotation point too.
        if (accept) begin
            last_grant_d = gnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            last_grant_q <= M'(N - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

`ifdef STREAM_MUX_RR_XFER_CNT_EN
    logic [15:0] xfer_cnt_q;

    // Counts output handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes, chosen at run time:
  - fixed: external `sel` picks the channel.
  - round-robin: fair rotation among requesting channels.
- One registered output stage. Sits between multiple producer blocks and a single consumer.
- Successor of the combinational 1-bit mux: adds a data width, flow control, arbitration and registered output.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- M, 2, width of `sel` and `out_ch`; must satisfy 2^M >= N.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, N, per-channel valid; bit i belongs to channel i.
- in_data, input, N*W, channel i occupies bits [i*W +: W].
- in_ready, output, N, per-channel ready (combinational).
- sel, input, M, channel select in fixed mode.
- mode, input, 1, 0 = fixed, 1 = round-robin.
- out_valid, output, 1, output register holds data.
- out_data, output, W, registered data.
- out_ch, output, M, index of the channel that supplied out_data.
- out_ready, input, 1, consumer accepts when high with out_valid.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last_grant=N-1, so channel 0 has first priority after reset.
  - Reset mid-transfer discards held data. in_ready is all 0 while rst=1.
- Load enable: `load = !out_valid || out_ready`. A register can be refilled in the same cycle it drains, giving full throughput of 1 word/cycle.
- Grant (combinational):
  - fixed mode: `gnt = sel`, only if sel < N and in_valid[sel]=1. sel >= N gives no grant.
  - round-robin mode: first i with in_valid[i]=1, searching from (last_grant+1) mod N upward with wrap-around. No valid inputs gives no grant.
- in_ready[i] = load && grant exists && gnt==i. At most one bit is high; all others are 0.
- On a clk edge with load=1:
  - Grant exists: out_data <= in_data[gnt], out_ch <= gnt, out_valid <= 1.
  - No grant: out_valid <= 0 (out_data and out_ch hold).
- On a clk edge with load=0: all output registers hold; data is stable while out_valid && !out_ready.
- last_grant updates to gnt only on an accepted transfer (in_valid[gnt] && in_ready[gnt]), in both modes. Fixed-mode transfers therefore shift round-robin priority.
- Latency: an input handshake in cycle t makes the data visible at out_data in cycle t+1.
- Mode or sel may change any cycle. The new value takes effect in that cycle's grant; the held output is unaffected.
- Producers must hold in_data stable while in_valid=1 and in_ready=0; the block does not check this.
- N=1: grant is always channel 0 when valid; out_ch=0.

Optional Feature:
- Macro: STREAM_MUX_RR_XFER_CNT_EN.
- Defined:
  - Extra output port xfer_cnt [15:0].
  - Counts output handshakes (out_valid && out_ready), +1 per cycle, wraps 16'hFFFF -> 0.
  - Cleared to 0 by rst.
- Undefined: port and counter do not exist; behaviour otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all in_valid=0 -> out_valid=0, in_ready=4'b0000, out_data=0, out_ch=0.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one word per cycle, no gaps.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0000 and out_data stable for 3 cycles; raise out_ready -> the held word drains and the next grant loads in the same cycle.
- Sparse round-robin with wrap: mode=1, only ch3 and ch0 valid, last_grant=3 -> ch0 granted first, then ch3, then ch0.
- Mid-operation reset and counter: reset asserted while out_valid=1 -> next cycle out_valid=0 and last_grant=3. With STREAM_MUX_RR_XFER_CNT_EN defined, 5 handshakes -> xfer_cnt=5, and reset returns it to 0.
